// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: collects an (A, B, OPCODE) command frame from a byte-wide
// serial receiver, presents the registered operands to a combinational ALU, and
// returns the (RESULT, FLAGS) response through the transmitter handshake.
// One frame is in flight at a time; bytes arriving while busy are dropped.
module alu_uart_sequencer #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  input  logic               i_alu_zero,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_RES  = 3'd4,
    S_TX_FLG  = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             byte_accept;
  logic             timeout_hit;
  logic             tx_start_d;
  logic             busy_d;
  logic [CNT_W-1:0] idle_cnt;
  logic [7:0]       res_q;
  logic [7:0]       flg_q;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_WAIT_A;
    else         state <= next_state;
  end

  // Next-state decode; a byte on the expiry cycle beats the timeout
  always_comb begin
    next_state  = state;
    byte_accept = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_WAIT_A: begin
        if (i_rx_valid) begin
          byte_accept = 1'b1;
          next_state  = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_valid) begin
          byte_accept = 1'b1;
          next_state  = S_WAIT_OP;
        end else if (idle_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_valid) begin
          byte_accept = 1'b1;
          next_state  = S_EXEC;
        end else if (idle_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          next_state  = S_WAIT_A;
        end
      end
      S_EXEC:   next_state = S_TX_RES;
      S_TX_RES: if (i_tx_done) next_state = S_TX_FLG;
      S_TX_FLG: if (i_tx_done) next_state = S_WAIT_A;
      default:  next_state = S_WAIT_A;
    endcase
  end

  // Start pulse fires on the first cycle of each transmit state
  always_comb begin
    tx_start_d = ((next_state == S_TX_RES) && (state != S_TX_RES)) ||
                 ((next_state == S_TX_FLG) && (state != S_TX_FLG));
    busy_d     = (next_state == S_EXEC) || (next_state == S_TX_RES) ||
                 (next_state == S_TX_FLG);
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_tx_start  <= tx_start_d;
      o_busy      <= busy_d;
      o_frame_err <= timeout_hit;
    end
  end

  // Operand/opcode capture from the receiver and result/flag capture in EXEC
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      res_q        <= '0;
      flg_q        <= '0;
    end else begin
      if (byte_accept) begin
        case (state)
          S_WAIT_A:  o_alu_data_a <= i_rx_data;
          S_WAIT_B:  o_alu_data_b <= i_rx_data;
          S_WAIT_OP: o_alu_op     <= i_rx_data[NB_OP-1:0];
          default:   ;
        endcase
      end
      if (state == S_EXEC) begin
        res_q <= i_alu_result;
        flg_q <= {6'b0, i_alu_overflow, i_alu_zero};
      end
    end
  end

  // Inter-byte idle counter; saturates at the expiry value instead of wrapping
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      idle_cnt <= '0;
    end else if (byte_accept || timeout_hit ||
                 ((state != S_WAIT_B) && (state != S_WAIT_OP))) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_LAST) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Transmit byte chosen from registered state so it stays put until done
  always_comb begin
    o_tx_data = (state == S_TX_FLG) ? flg_q : res_q;
  end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed testbench for alu_uart_sequencer with a small behavioural ALU and
// a hand-driven transmitter handshake.
module tb_alu_uart_sequencer;

  localparam int TO = 16;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_ovf;
  logic       alu_zero;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       busy;
  logic       frame_err;

  int vectors;
  int miscompares;

  alu_uart_sequencer #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_alu_data_a(alu_a),
    .o_alu_data_b(alu_b),
    .o_alu_op(alu_op),
    .i_alu_result(alu_result),
    .i_alu_overflow(alu_ovf),
    .i_alu_zero(alu_zero),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_done(tx_done),
    .o_busy(busy),
    .o_frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: carry/borrow out reported as overflow
  always_comb begin
    logic [8:0] wide;
    wide = 9'h000;
    case (alu_op)
      6'h20:   wide = {1'b0, alu_a} + {1'b0, alu_b};
      6'h22:   wide = {1'b0, alu_a} - {1'b0, alu_b};
      6'h24:   wide = {1'b0, alu_a & alu_b};
      6'h25:   wide = {1'b0, alu_a | alu_b};
      6'h26:   wide = {1'b0, alu_a ^ alu_b};
      6'h27:   wide = {1'b0, ~(alu_a | alu_b)};
      default: wide = 9'h000;
    endcase
    alu_result = wide[7:0];
    alu_ovf    = wide[8];
    alu_zero   = (wide[7:0] == 8'h00);
  end

  // Must be called at a negedge; returns at the negedge after acceptance
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic expect_tx(input string name, input logic [7:0] exp,
                           input int delay, input bit inject);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (tx_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s start: got %b want 1 (no start within bound)", name, tx_start);
      return;
    end
    vectors++;
    if (tx_data !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s data: got %h want %h", name, tx_data, exp);
    end
    for (int i = 0; i < delay; i++) begin
      rx_data  = 8'hAA;
      rx_valid = inject && (i % 2 == 0);
      @(negedge clk);
      vectors++;
      if (tx_data !== exp || tx_start !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL %s hold: got data %h start %b want %h 0", name, tx_data, tx_start, exp);
      end
    end
    rx_valid = 1'b0;
    tx_done  = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s idle: got busy %b start %b want 0 0", name, busy, tx_start);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got a=%h b=%h op=%h tx=%h st=%b busy=%b err=%b want all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    vectors++;
    if (alu_op !== 6'h20 || tx_start !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_exec: got op=%h start=%b busy=%b want 20 0 1", alu_op, tx_start, busy);
    end
    @(negedge clk);
    vectors++;
    if (tx_start !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got start %b want 1", tx_start);
    end
    expect_tx("add_res", 8'h08, 2, 1'b0);
    expect_tx("add_flg", 8'h00, 0, 1'b0);
    check_idle("add");
  endtask

  task automatic test_overflow();
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h20);
    expect_tx("ovf_res", 8'h00, 0, 1'b0);
    expect_tx("ovf_flg", 8'h03, 1, 1'b0);
    check_idle("ovf");
  endtask

  task automatic test_sub_nor();
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'h22);
    expect_tx("sub_res", 8'hFE, 0, 1'b0);
    expect_tx("sub_flg", 8'h02, 0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h0F);
    send_byte(8'hE7);
    vectors++;
    if (alu_op !== 6'h27) begin
      miscompares++;
      $display("[TB] FAIL nor_op_mask: got %h want 27", alu_op);
    end
    expect_tx("nor_res", 8'h00, 0, 1'b0);
    expect_tx("nor_flg", 8'h01, 0, 1'b0);
    check_idle("nor");
  endtask

  task automatic test_timeout();
    int pulses;
    int first_at;
    pulses   = 0;
    first_at = -1;
    send_byte(8'h11);
    for (int i = 1; i <= TO + 2; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
    vectors++;
    if (pulses != 1 || first_at != TO) begin
      miscompares++;
      $display("[TB] FAIL timeout_pulse: got %0d pulses at %0d want 1 at %0d", pulses, first_at, TO);
    end
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h24);
    vectors++;
    if (alu_a !== 8'h01 || alu_b !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL timeout_realign: got a=%h b=%h want 01 01", alu_a, alu_b);
    end
    expect_tx("and_res", 8'h01, 0, 1'b0);
    expect_tx("and_flg", 8'h00, 0, 1'b0);
  endtask

  task automatic test_expiry_byte_wins();
    int pulses;
    pulses = 0;
    send_byte(8'h07);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1) pulses++;
    end
    send_byte(8'h02);
    if (frame_err === 1'b1) pulses++;
    send_byte(8'h26);
    if (frame_err === 1'b1) pulses++;
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL expiry_byte: got %0d error pulses want 0", pulses);
    end
    expect_tx("xor_res", 8'h05, 0, 1'b0);
    expect_tx("xor_flg", 8'h00, 0, 1'b0);
  endtask

  task automatic test_busy_drop();
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h25);
    expect_tx("drop_res", 8'h30, 20, 1'b1);
    expect_tx("drop_flg", 8'h00, 3, 1'b1);
    repeat (3) @(negedge clk);
    check_idle("drop");
    vectors++;
    if (alu_a !== 8'h10 || alu_b !== 8'h20 || alu_op !== 6'h25) begin
      miscompares++;
      $display("[TB] FAIL drop_operands: got a=%h b=%h op=%h want 10 20 25", alu_a, alu_b, alu_op);
    end
  endtask

  task automatic test_reset_mid_tx();
    send_byte(8'h09);
    send_byte(8'h04);
    send_byte(8'h22);
    expect_tx("rst_res", 8'h05, 0, 1'b0);
    vectors++;
    if (tx_start !== 1'b1 || tx_data !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rst_flg_entry: got start %b data %h want 1 00", tx_start, tx_data);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got a=%h b=%h op=%h tx=%h st=%b busy=%b err=%b want all 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy, frame_err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h20);
    expect_tx("post_rst_res", 8'h05, 0, 1'b0);
    expect_tx("post_rst_flg", 8'h00, 0, 1'b0);
    check_idle("post_rst");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_overflow();
    test_sub_nor();
    test_timeout();
    test_expiry_byte_wins();
    test_busy_drop();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog against a hung sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
